// File: rtl/xadc_sample_averager_if.sv
// -----------------------------------------------------------------------------
// xadc_sample_averager_if
//   DRP read channel between the sample averager (master) and the XADC hard
//   block (slave). Only the read path is carried; the averager never writes.
//
//   den    master -> slave  one-cycle read enable
//   daddr  master -> slave  7-bit register address
//   drdy   slave  -> master read data valid
//   dout   slave  -> master 16-bit read data (XADC do_out)
// -----------------------------------------------------------------------------
interface xadc_sample_averager_if;
  logic        den;
  logic [6:0]  daddr;
  logic        drdy;
  logic [15:0] dout;

  modport master (
    output den,
    output daddr,
    input  drdy,
    input  dout
  );

  modport slave (
    input  den,
    input  daddr,
    output drdy,
    output dout
  );
endinterface

// File: rtl/xadc_sample_averager.sv
// -----------------------------------------------------------------------------
// xadc_sample_averager
//   Sits on the XADC DRP port. On every end-of-conversion for CHANNEL it issues
//   a single DRP read, keeps the 12 MSBs of the result and accumulates
//   2**LOG2_AVG samples. When the window is full the truncated mean is
//   published on o_avg_data with a one-cycle o_avg_valid strobe.
//   A matching EOC that arrives while a read is in flight is dropped and
//   flagged on o_overrun; a read whose drdy never comes is abandoned after
//   TIMEOUT cycles and flagged on o_timeout.
//
// Parameters
//   CHANNEL   XADC channel accepted (default VAUX5 = 5'd21)
//   LOG2_AVG  log2 of samples per average, 0..8 (0 = pass-through)
//   TIMEOUT   cycles to wait for drdy before aborting, 1..255
//
// Ports
//   clk           system clock, also the XADC dclk
//   rst           synchronous reset, active high
//   i_eoc         XADC eoc_out
//   i_channel     XADC channel_out, qualified by i_eoc
//   drp           DRP read master (den/daddr out, drdy/dout in)
//   o_avg_data    mean of the last complete window, unsigned
//   o_avg_valid   one-cycle strobe, o_avg_data just updated
//   o_busy        high whenever the read FSM is not idle
//   o_overrun     one-cycle pulse, matching EOC dropped because busy
//   o_timeout     one-cycle pulse, DRP read abandoned
//   o_min_data    (XADC_AVG_MINMAX_EN) minimum sample of the last window
//   o_max_data    (XADC_AVG_MINMAX_EN) maximum sample of the last window
//
// Build option
//   XADC_AVG_MINMAX_EN  when defined, adds per-window min/max tracking and
//                       the o_min_data / o_max_data outputs.
// -----------------------------------------------------------------------------
module xadc_sample_averager #(
  parameter logic [4:0]  CHANNEL  = 5'd21,
  parameter int unsigned LOG2_AVG = 4,
  parameter int unsigned TIMEOUT  = 63
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_eoc,
  input  logic [4:0]                    i_channel,
  xadc_sample_averager_if.master        drp,
  output logic [11:0]                   o_avg_data,
  output logic                          o_avg_valid,
  output logic                          o_busy,
  output logic                          o_overrun,
  output logic                          o_timeout
`ifdef XADC_AVG_MINMAX_EN
  ,
  output logic [11:0]                   o_min_data,
  output logic [11:0]                   o_max_data
`endif
);

  // Accumulator is wide enough for 2**LOG2_AVG full-scale 12-bit samples.
  localparam int unsigned ACC_W = 12 + LOG2_AVG;
  // Sample counter keeps at least one bit so LOG2_AVG = 0 still elaborates.
  localparam int unsigned CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((1 << LOG2_AVG) - 1);
  localparam logic [7:0]       WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_ACC
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic               w_eoc_match;
  logic               w_wait_expired;
  logic               w_win_full;
  logic [7:0]         r_wait_cnt;
  logic [11:0]        r_sample;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   w_sum;
  logic [11:0]        w_mean;
  logic [CNT_W-1:0]   r_cnt;
  logic [11:0]        r_avg_data;
  logic               r_avg_valid;
  logic               r_overrun;
  logic               w_unused_lsb;

  assign w_eoc_match    = i_eoc && (i_channel == CHANNEL);
  assign w_wait_expired = (r_wait_cnt == WAIT_LAST);
  assign w_win_full     = (r_cnt == CNT_LAST);

  // Sum including the sample being accumulated this cycle; the mean is the
  // upper 12 bits, i.e. a truncating divide by 2**LOG2_AVG.
  assign w_sum  = r_acc + ACC_W'(r_sample);
  assign w_mean = w_sum[ACC_W-1:LOG2_AVG];

  // The XADC left-justifies its 12-bit result; the low nibble carries nothing.
  assign w_unused_lsb = ^drp.dout[3:0];

  assign drp.daddr = {2'b00, CHANNEL};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking (<=) in every clocked process so all registers update
    // from the values they held before the edge, independent of process order.
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so every path drives the signal and no
    // latch is inferred.
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: if (w_eoc_match) w_next_state = S_REQ;
      S_REQ:  w_next_state = S_WAIT;  // drdy cannot legally arrive with den
      S_WAIT: begin
        if (drp.drdy) begin
          w_next_state = S_ACC;
        end else if (w_wait_expired) begin
          w_next_state = S_IDLE;
        end
      end
      S_ACC:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    drp.den   = 1'b0;
    o_busy    = 1'b1;
    o_timeout = 1'b0;
    unique case (r_state)
      S_IDLE: o_busy  = 1'b0;
      S_REQ:  drp.den = 1'b1;
      // Abort is flagged in the last WAIT cycle, the one that returns to IDLE.
      S_WAIT: o_timeout = !drp.drdy && w_wait_expired;
      S_ACC:  ;
      default: o_busy = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // drdy wait counter: counts WAIT cycles, cleared everywhere else.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample capture. Only drdy seen in WAIT is taken, so a late drdy after a
  // reset or a timeout never reaches the accumulator.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: r_sample is pure datapath with no reset: it is always written in
    // WAIT before ACC reads it, so its power-up value is never observed.
    if (r_state == S_WAIT && drp.drdy) begin
      r_sample <= drp.dout[15:4];
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulator, window counter and published average.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_avg_data  <= '0;
      r_avg_valid <= 1'b0;
    end else begin
      r_avg_valid <= 1'b0;
      if (r_state == S_ACC) begin
        if (w_win_full) begin
          r_avg_data  <= w_mean;
          r_avg_valid <= 1'b1;
          r_acc       <= '0;
          r_cnt       <= '0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Overrun: a matching EOC while any read is in progress is dropped.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_eoc_match && (r_state != S_IDLE);
    end
  end

  assign o_avg_data  = r_avg_data;
  assign o_avg_valid = r_avg_valid;
  assign o_overrun   = r_overrun;

`ifdef XADC_AVG_MINMAX_EN
  // ---------------------------------------------------------------------------
  // Per-window min/max. The running values are re-armed to the opposite
  // extremes when a window closes so the next window starts clean.
  // ---------------------------------------------------------------------------
  logic [11:0] r_run_min;
  logic [11:0] r_run_max;
  logic [11:0] r_min_data;
  logic [11:0] r_max_data;
  logic [11:0] w_new_min;
  logic [11:0] w_new_max;

  assign w_new_min = (r_sample < r_run_min) ? r_sample : r_run_min;
  assign w_new_max = (r_sample > r_run_max) ? r_sample : r_run_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run_min  <= 12'hFFF;
      r_run_max  <= 12'h000;
      r_min_data <= '0;
      r_max_data <= '0;
    end else if (r_state == S_ACC) begin
      if (w_win_full) begin
        r_min_data <= w_new_min;
        r_max_data <= w_new_max;
        r_run_min  <= 12'hFFF;
        r_run_max  <= 12'h000;
      end else begin
        r_run_min <= w_new_min;
        r_run_max <= w_new_max;
      end
    end
  end

  assign o_min_data = r_min_data;
  assign o_max_data = r_max_data;
`endif

endmodule

// File: tb/tb_xadc_sample_averager.sv
// -----------------------------------------------------------------------------
// tb_xadc_sample_averager
//   Drives xadc_sample_averager as the XADC would (EOC strobes, DRP drdy/do)
//   and checks it against a window-of-samples reference model. Expected
//   averages are queued when a sample is handed to the DUT and popped by a
//   separate monitor whenever o_avg_valid is seen.
// -----------------------------------------------------------------------------
module tb_xadc_sample_averager;

  localparam int unsigned LOG2_AVG = 2;
  localparam int unsigned N_AVG    = 1 << LOG2_AVG;
  localparam int unsigned TIMEOUT  = 15;
  localparam logic [4:0]  CHANNEL  = 5'd21;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        eoc  = 1'b0;
  logic [4:0]  chan = 5'd0;
  logic [11:0] avg_data;
  logic        avg_valid;
  logic        busy;
  logic        overrun;
  logic        timeout;
`ifdef XADC_AVG_MINMAX_EN
  logic [11:0] min_data;
  logic [11:0] max_data;
`endif

  xadc_sample_averager_if dif ();

  xadc_sample_averager #(
    .CHANNEL  (CHANNEL),
    .LOG2_AVG (LOG2_AVG),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_eoc       (eoc),
    .i_channel   (chan),
    .drp         (dif),
    .o_avg_data  (avg_data),
    .o_avg_valid (avg_valid),
    .o_busy      (busy),
    .o_overrun   (overrun),
    .o_timeout   (timeout)
`ifdef XADC_AVG_MINMAX_EN
    ,
    .o_min_data  (min_data),
    .o_max_data  (max_data)
`endif
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [11:0] avg;
    logic [11:0] mn;
    logic [11:0] mx;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned win_q[$];
  exp_t        mon_e;
  int          checks    = 0;
  int          errors    = 0;
  int          den_cnt   = 0;
  int          exp_den   = 0;
  int          ovr_cnt   = 0;
  int          to_cnt    = 0;
  int          valid_cnt = 0;
  int          exp_wins  = 0;
  logic        prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collect samples; a full window yields mean/min/max.
  function automatic void model_accept(input logic [11:0] s);
    exp_t        e;
    int unsigned sum;
    win_q.push_back(int'(s));
    if (win_q.size() == N_AVG) begin
      sum  = 0;
      e.mn = 12'hFFF;
      e.mx = 12'h000;
      foreach (win_q[i]) begin
        sum += win_q[i];
        if (win_q[i] < e.mn) e.mn = 12'(win_q[i]);
        if (win_q[i] > e.mx) e.mx = 12'(win_q[i]);
      end
      e.avg = 12'(sum / N_AVG);
      exp_q.push_back(e);
      exp_wins++;
      win_q.delete();
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: samples on the falling edge, away from the active edge.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst) begin
      if (dif.den) begin
        den_cnt++;
        check("daddr", 32'(dif.daddr), 32'h15);
      end
      if (overrun) ovr_cnt++;
      if (timeout) to_cnt++;
      if (avg_valid) begin
        valid_cnt++;
        check("valid_back_to_back", 32'(prev_valid), 32'd0);
        check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("avg_data", 32'(avg_data), 32'(mon_e.avg));
`ifdef XADC_AVG_MINMAX_EN
          check("min_data", 32'(min_data), 32'(mon_e.mn));
          check("max_data", 32'(max_data), 32'(mon_e.mx));
`endif
        end
      end
      prev_valid = avg_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // Hard stop in case something wedges the stimulus.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. All drives happen 1 time unit after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_eoc(input logic [4:0] ch);
    step();
    eoc  = 1'b1;
    chan = ch;
    step();
    eoc  = 1'b0;
    chan = 5'($urandom);
  endtask

  // Matching EOC, then confirm den the very next cycle.
  task automatic start_read();
    send_eoc(CHANNEL);
    exp_den++;
    @(negedge clk);
    check("den_latency", 32'(dif.den), 32'd1);
  endtask

  // Called 1 unit after the edge of a WAIT cycle: present drdy with data.
  task automatic finish_read(input logic [15:0] d);
    bit done;
    dif.drdy = 1'b1;
    dif.dout = d;
    model_accept(d[15:4]);
    done = (win_q.size() == 0);
    step();
    dif.drdy = 1'b0;
    dif.dout = 16'($urandom);
    @(negedge clk);
    check("busy_in_acc", 32'(busy), 32'd1);
    check("no_early_valid", 32'(avg_valid), 32'd0);
    @(negedge clk);
    check("avg_valid_latency", 32'(avg_valid), 32'(done));
    check("idle_after_read", 32'(busy), 32'd0);
  endtask

  task automatic drp_read(input logic [15:0] d, input int k);
    start_read();
    repeat (k) @(posedge clk);
    #1;
    finish_read(d);
  endtask

  task automatic rand_read();
    drp_read(16'($urandom), int'($urandom_range(6, 1)));
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int          found;
    logic [4:0]  other;

    dif.drdy = 1'b0;
    dif.dout = 16'h0000;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_avg_data",  32'(avg_data),  32'd0);
    check("rst_avg_valid", 32'(avg_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_overrun",   32'(overrun),   32'd0);
    check("rst_timeout",   32'(timeout),   32'd0);
    check("rst_den",       32'(dif.den),   32'd0);
    check("rst_daddr",     32'(dif.daddr), 32'h15);
`ifdef XADC_AVG_MINMAX_EN
    check("rst_min_data",  32'(min_data),  32'd0);
    check("rst_max_data",  32'(max_data),  32'd0);
`endif
    step();
    rst = 1'b0;

    // Four reads, drdy three cycles after den -> mean 0x280
    drp_read(16'h1000, 3);
    drp_read(16'h2000, 3);
    drp_read(16'h3000, 3);
    drp_read(16'h4000, 3);
    check("den_count_first_window", 32'(den_cnt), 32'd4);

    // Truncation: 1,1,1,2 -> 1
    drp_read(16'h0010, 2);
    drp_read(16'h0010, 1);
    drp_read(16'h0010, 4);
    drp_read(16'h0020, 2);

    // Foreign channel only: nothing happens
    send_eoc(5'h03);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("foreign_den",     32'(dif.den), 32'd0);
      check("foreign_busy",    32'(busy),    32'd0);
      check("foreign_overrun", 32'(overrun), 32'd0);
    end

    // Overrun: matching EOC in WAIT, then a foreign EOC; one sample only
    start_read();
    step();
    eoc  = 1'b1;
    chan = CHANNEL;
    step();
    chan = 5'h03;
    @(negedge clk);
    check("overrun_pulse", 32'(overrun), 32'd1);
    step();
    eoc = 1'b0;
    @(negedge clk);
    check("overrun_single", 32'(overrun), 32'd0);
    check("overrun_still_busy", 32'(busy), 32'd1);
    step();
    finish_read(16'($urandom));
    repeat (N_AVG - 1) rand_read();

    // Timeout in the middle of a window; window must carry on unharmed
    rand_read();
    rand_read();
    start_read();
    found = -1;
    for (int j = 1; j <= int'(TIMEOUT) + 4; j++) begin
      @(negedge clk);
      if (timeout && found < 0) found = j;
    end
    check("timeout_cycle", 32'(found), 32'(TIMEOUT));
    check("timeout_idle", 32'(busy), 32'd0);
    rand_read();
    rand_read();

    // Reset while waiting for drdy; late drdy must be ignored
    rand_read();
    start_read();
    step();
    rst = 1'b1;
    step();
    rst      = 1'b0;
    dif.drdy = 1'b1;
    dif.dout = 16'hFFF0;
    win_q.delete();
    step();
    dif.drdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_avg_valid", 32'(avg_valid), 32'd0);
      check("post_rst_busy",      32'(busy),      32'd0);
      check("post_rst_avg_data",  32'(avg_data),  32'd0);
    end
    repeat (N_AVG) rand_read();

    // Min/max window: 0x100, 0x050, 0x3FF, 0x200
    drp_read(16'h1000, 2);
    drp_read(16'h0500, 3);
    drp_read(16'h3FF0, 1);
    drp_read(16'h2000, 5);

    // Random traffic with interleaved foreign EOCs
    for (int w = 0; w < 3 * int'(N_AVG); w++) begin
      if ($urandom_range(1, 0) == 1) begin
        other = 5'($urandom);
        if (other == CHANNEL) other = other ^ 5'h01;
        send_eoc(other);
      end
      rand_read();
    end

    // Drain and final tallies
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("den_total",     32'(den_cnt),   32'(exp_den));
    check("valid_total",   32'(valid_cnt), 32'(exp_wins));
    check("overrun_total", 32'(ovr_cnt),   32'd1);
    check("timeout_total", 32'(to_cnt),    32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
